// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: control words, main-decoder
// operation classes and the sequencer FSM state type.
package alu_ctrl_pkg;

    localparam logic [2:0] CTRL_ADD = 3'd0;
    localparam logic [2:0] CTRL_SUB = 3'd1;
    localparam logic [2:0] CTRL_AND = 3'd2;
    localparam logic [2:0] CTRL_OR  = 3'd3;
    localparam logic [2:0] CTRL_SLT = 3'd4;
    localparam logic [2:0] CTRL_XOR = 3'd5;
    localparam logic [2:0] CTRL_NOR = 3'd6;
    localparam logic [2:0] CTRL_MUL = 3'd7;

    localparam logic [2:0] AOP_ADD   = 3'b000;
    localparam logic [2:0] AOP_SUB   = 3'b001;
    localparam logic [2:0] AOP_MEM   = 3'b010;
    localparam logic [2:0] AOP_AND   = 3'b011;
    localparam logic [2:0] AOP_OR    = 3'b100;
    localparam logic [2:0] AOP_SLT   = 3'b101;
    localparam logic [2:0] AOP_RSVD  = 3'b110;
    localparam logic [2:0] AOP_RTYPE = 3'b111;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluop/func -> ALU control table; zero latency, no flow control.
// Multiply decode exists only when ALU_CONTROL_SEQ_MUL_EN is defined.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W = 3
) (
    input  logic [2:0]        aluop,
    input  logic [FUNC_W-1:0] func,
    output logic [2:0]        ctrl,
`ifdef ALU_CONTROL_SEQ_MUL_EN
    output logic              is_mul,
`endif
    output logic              illegal
);

    always_comb begin
        ctrl    = CTRL_ADD;
        illegal = 1'b0;
`ifdef ALU_CONTROL_SEQ_MUL_EN
        is_mul  = 1'b0;
`endif
        case (aluop)
            AOP_ADD, AOP_MEM: ctrl = CTRL_ADD;
            AOP_SUB:          ctrl = CTRL_SUB;
            AOP_AND:          ctrl = CTRL_AND;
            AOP_OR:           ctrl = CTRL_OR;
            AOP_SLT:          ctrl = CTRL_SLT;
            AOP_RSVD:         illegal = 1'b1;
            AOP_RTYPE: begin
                // Only the low three function bits carry meaning.
                case (func[2:0])
                    3'b000: ctrl = CTRL_ADD;
                    3'b001: ctrl = CTRL_SUB;
                    3'b010: ctrl = CTRL_AND;
                    3'b011: ctrl = CTRL_OR;
                    3'b100: ctrl = CTRL_SLT;
                    3'b101: ctrl = CTRL_XOR;
                    3'b110: ctrl = CTRL_NOR;
                    default: begin
`ifdef ALU_CONTROL_SEQ_MUL_EN
                        ctrl   = CTRL_MUL;
                        is_mul = 1'b1;
`else
                        illegal = 1'b1;
`endif
                    end
                endcase
            end
            default: ctrl = CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: latency 1 (multiply MULT_CYCLES+1, with ALU_CONTROL_SEQ_MUL_EN);
// ready_o drops while a multiply runs, requests offered then are ignored, not queued.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W      = 3,
    parameter int CTRL_W      = 3,
    parameter int MULT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [2:0]        aluop_i,
    input  logic [FUNC_W-1:0] func_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              ctrl_valid_o,
    output logic              mult_busy_o,
    output logic              illegal_o
);

    logic [2:0]        dec_ctrl;
    logic              dec_illegal;
    logic              accept;
    logic [CTRL_W-1:0] ctrl_d;
    logic              ctrl_valid_d;
    logic              illegal_d;

    assign accept = valid_i & ready_o & ~flush_i;

`ifdef ALU_CONTROL_SEQ_MUL_EN
    localparam int              CNT_W    = $clog2(MULT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec_is_mul;

    alu_ctrl_decode #(.FUNC_W(FUNC_W)) u_decode (
        .aluop   (aluop_i),
        .func    (func_i),
        .ctrl    (dec_ctrl),
        .is_mul  (dec_is_mul),
        .illegal (dec_illegal)
    );

    assign ready_o     = (state_q == IDLE);
    assign mult_busy_o = (state_q == MUL_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_o;
        ctrl_valid_d = 1'b0;
        illegal_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_is_mul) begin
                        state_d = MUL_RUN;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        ctrl_d       = CTRL_W'(dec_ctrl);
                        ctrl_valid_d = 1'b1;
                        illegal_d    = dec_illegal;
                    end
                end
            end
            MUL_RUN: begin
                // Flush beats completion: a cancelled multiply never pulses.
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d      = IDLE;
                    ctrl_d       = CTRL_W'(CTRL_MUL);
                    ctrl_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
`else
    alu_ctrl_decode #(.FUNC_W(FUNC_W)) u_decode (
        .aluop   (aluop_i),
        .func    (func_i),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign ready_o     = 1'b1;
    assign mult_busy_o = 1'b0;

    always_comb begin
        ctrl_d       = ctrl_o;
        ctrl_valid_d = 1'b0;
        illegal_d    = 1'b0;
        if (accept) begin
            ctrl_d       = CTRL_W'(dec_ctrl);
            ctrl_valid_d = 1'b1;
            illegal_d    = dec_illegal;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_o       <= '0;
            ctrl_valid_o <= 1'b0;
            illegal_o    <= 1'b0;
        end else begin
            ctrl_o       <= ctrl_d;
            ctrl_valid_o <= ctrl_valid_d;
            illegal_o    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table, back-to-back issue, flush,
// reset and (when ALU_CONTROL_SEQ_MUL_EN is defined) multiply sequencing.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_i = 1'b0;
    logic [2:0] aluop_i = 3'b000;
    logic [2:0] func_i = 3'b000;
    logic       flush_i = 1'b0;

    logic       ready_o, ctrl_valid_o, mult_busy_o, illegal_o;
    logic [2:0] ctrl_o;
    logic       ready1, ctrl_valid1, mult_busy1, illegal1;
    logic [2:0] ctrl1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_control_seq #(.FUNC_W(3), .CTRL_W(3), .MULT_CYCLES(8)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .valid_i      (valid_i),
        .aluop_i      (aluop_i),
        .func_i       (func_i),
        .flush_i      (flush_i),
        .ready_o      (ready_o),
        .ctrl_o       (ctrl_o),
        .ctrl_valid_o (ctrl_valid_o),
        .mult_busy_o  (mult_busy_o),
        .illegal_o    (illegal_o)
    );

    alu_control_seq #(.FUNC_W(3), .CTRL_W(3), .MULT_CYCLES(1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .valid_i      (valid_i),
        .aluop_i      (aluop_i),
        .func_i       (func_i),
        .flush_i      (flush_i),
        .ready_o      (ready1),
        .ctrl_o       (ctrl1),
        .ctrl_valid_o (ctrl_valid1),
        .mult_busy_o  (mult_busy1),
        .illegal_o    (illegal1)
    );

    typedef struct {
        logic [2:0] aluop;
        logic [2:0] func;
        int         ctrl;
        int         ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input int c, input int v, input int il,
                             input int rdy, input int busy);
        check({name, ".ctrl_o"}, int'(ctrl_o), c);
        check({name, ".ctrl_valid_o"}, int'(ctrl_valid_o), v);
        check({name, ".illegal_o"}, int'(illegal_o), il);
        check({name, ".ready_o"}, int'(ready_o), rdy);
        check({name, ".mult_busy_o"}, int'(mult_busy_o), busy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int last_ctrl;
        int pulses;

        // Asynchronous reset with no clock edge yet.
        #2 reset = 1'b1;
        #1;
        check_out("reset_async", 0, 0, 0, 1, 0);
        tick();
        reset = 1'b0;

        // First edge after reset release accepts: R-type SUB.
        valid_i = 1'b1; aluop_i = 3'b111; func_i = 3'b001;
        tick();
        check_out("first_sub", 1, 1, 0, 1, 0);

        // Back-to-back 000, 011, 101 -> 0, 2, 4.
        aluop_i = 3'b000; func_i = 3'b000; tick();
        check_out("b2b_add", 0, 1, 0, 1, 0);
        aluop_i = 3'b011; tick();
        check_out("b2b_and", 2, 1, 0, 1, 0);
        aluop_i = 3'b101; tick();
        check_out("b2b_slt", 4, 1, 0, 1, 0);

        vecs.push_back('{3'b000, 3'b101, 0, 0});
        vecs.push_back('{3'b001, 3'b110, 1, 0});
        vecs.push_back('{3'b110, 3'b011, 0, 1});
        vecs.push_back('{3'b010, 3'b111, 0, 0});
        vecs.push_back('{3'b011, 3'b000, 2, 0});
        vecs.push_back('{3'b100, 3'b001, 3, 0});
        vecs.push_back('{3'b101, 3'b010, 4, 0});
        vecs.push_back('{3'b111, 3'b000, 0, 0});
        vecs.push_back('{3'b111, 3'b010, 2, 0});
        vecs.push_back('{3'b111, 3'b011, 3, 0});
        vecs.push_back('{3'b110, 3'b000, 0, 1});
        vecs.push_back('{3'b111, 3'b100, 4, 0});
        vecs.push_back('{3'b111, 3'b101, 5, 0});
        vecs.push_back('{3'b111, 3'b110, 6, 0});
        vecs.push_back('{3'b111, 3'b001, 1, 0});
`ifndef ALU_CONTROL_SEQ_MUL_EN
        vecs.push_back('{3'b111, 3'b110, 6, 0});
        vecs.push_back('{3'b111, 3'b111, 0, 1});
`endif
        last_ctrl = 0;
        foreach (vecs[i]) begin
            valid_i = 1'b1; aluop_i = vecs[i].aluop; func_i = vecs[i].func;
            tick();
            check($sformatf("vec%0d.ctrl_o", i), int'(ctrl_o), vecs[i].ctrl);
            check($sformatf("vec%0d.ctrl_valid_o", i), int'(ctrl_valid_o), 1);
            check($sformatf("vec%0d.illegal_o", i), int'(illegal_o), vecs[i].ill);
            last_ctrl = vecs[i].ctrl;
        end

        // Idle: ctrl_o holds, no pulse.
        valid_i = 1'b0; aluop_i = 3'b011; func_i = 3'b000;
        tick();
        check_out("hold", last_ctrl, 0, 0, 1, 0);

        // Flush with valid in IDLE drops the request.
        valid_i = 1'b1; flush_i = 1'b1;
        tick();
        check_out("flush_idle", last_ctrl, 0, 0, 1, 0);
        valid_i = 1'b0; flush_i = 1'b0;
        tick();
        check_out("flush_idle_after", last_ctrl, 0, 0, 1, 0);

`ifdef ALU_CONTROL_SEQ_MUL_EN
        // Full multiply: busy cycles 1..8, pulse in cycle 9; mid-run valid ignored.
        valid_i = 1'b1; aluop_i = 3'b111; func_i = 3'b111;
        tick();
        valid_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_out($sformatf("mul_c%0d", c), last_ctrl, 0, 0, 0, 1);
            if (c == 3) begin valid_i = 1'b1; aluop_i = 3'b100; func_i = 3'b000; end
            if (c == 6) valid_i = 1'b0;
            tick();
        end
        check_out("mul_done", 7, 1, 0, 1, 0);
        tick();
        check_out("mul_no_queue", 7, 0, 0, 1, 0);

        // Flush in cycle 3 of a multiply.
        valid_i = 1'b1; aluop_i = 3'b111; func_i = 3'b111;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        check_out("flush_mul_c3", 7, 0, 0, 0, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_out("flush_mul_next", 7, 0, 0, 1, 0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ctrl_valid_o) pulses++;
        end
        check("flush_mul_no_pulse", pulses, 0);

        // Reset in cycle 5 of a fresh multiply.
        valid_i = 1'b1; aluop_i = 3'b111; func_i = 3'b111;
        tick();
        valid_i = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        check_out("mul_pre_reset", 7, 0, 0, 0, 1);
        #2 reset = 1'b1;
        #1;
        check_out("reset_mid_mul", 0, 0, 0, 1, 0);
        tick();
        reset = 1'b0;
        valid_i = 1'b1; aluop_i = 3'b100; func_i = 3'b000;
        tick();
        valid_i = 1'b0;
        check_out("post_reset_accept", 3, 1, 0, 1, 0);

        // MULT_CYCLES=1: pulse exactly two cycles after accept.
        do_reset();
        valid_i = 1'b1; aluop_i = 3'b111; func_i = 3'b111;
        tick();
        valid_i = 1'b0;
        check("mc1_c1.ctrl_valid", int'(ctrl_valid1), 0);
        check("mc1_c1.busy", int'(mult_busy1), 1);
        check("mc1_c1.ready", int'(ready1), 0);
        tick();
        check("mc1_c2.ctrl_valid", int'(ctrl_valid1), 1);
        check("mc1_c2.ctrl", int'(ctrl1), 7);
        check("mc1_c2.busy", int'(mult_busy1), 0);
        check("mc1_c2.illegal", int'(illegal1), 0);
`else
        // Without multiply support: func 111 is illegal ADD at latency 1, never busy.
        do_reset();
        check("nomul_reset.ctrl", int'(ctrl1), 0);
        valid_i = 1'b1; aluop_i = 3'b111; func_i = 3'b101;
        tick();
        aluop_i = 3'b111; func_i = 3'b111;
        tick();
        valid_i = 1'b0;
        check_out("nomul_func7", 0, 1, 1, 1, 0);
        check("nomul_dut1.ctrl", int'(ctrl1), 0);
        check("nomul_dut1.illegal", int'(illegal1), 1);
        check("nomul_dut1.busy", int'(mult_busy1), 0);
        tick();
        check_out("nomul_after", 0, 0, 0, 1, 0);
        #2 reset = 1'b1;
        #1;
        check_out("nomul_reset_async", 0, 0, 0, 1, 0);
        tick();
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 Parameter FUNC_W, default 3, sets the R-type function-field width; minimum 3, only the low 3 bits are decoded.
REQ-002 Parameter CTRL_W, default 3, sets the ALU control-word width; minimum 3, upper bits zero.
REQ-003 Parameter MULT_CYCLES, default 8, sets the multiply occupancy in cycles; minimum 1.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 valid_i  input  1  request present.
REQ-007 aluop_i  input  3  main-decoder ALU operation class.
REQ-008 func_i  input  FUNC_W  R-type function field.
REQ-009 flush_i  input  1  synchronous cancel of any request in flight.
REQ-010 ready_o  output  1  block accepts a request this cycle.
REQ-011 ctrl_o  output  CTRL_W  registered ALU control word.
REQ-012 ctrl_valid_o  output  1  one-cycle pulse: ctrl_o is valid.
REQ-013 mult_busy_o  output  1  multiply sequence in progress.
REQ-014 illegal_o  output  1  pulse alongside ctrl_valid_o for an undefined encoding.

Function
REQ-015 Control encodings: ADD=0, SUB=1, AND=2, OR=3, SLT=4, XOR=5, NOR=6, MUL=7.
REQ-016 aluop 000->ADD, 001->SUB, 010->ADD, 011->AND, 100->OR, 101->SLT; 110 is reserved and yields ADD with illegal_o=1.
REQ-017 aluop 111 decodes func[2:0]: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR, 110 NOR, 111 MUL.
REQ-018 A request is accepted on a rising edge where valid_i=1, ready_o=1 and flush_i=0.
REQ-019 FSM states: IDLE, MUL_RUN; ready_o=1 only in IDLE.
REQ-020 A non-MUL accept in IDLE drives ctrl_o and a ctrl_valid_o pulse in the next cycle (latency 1), and the FSM stays in IDLE, sustaining back-to-back issue.
REQ-021 A MUL accept enters MUL_RUN, loads the down-counter with MULT_CYCLES-1, and asserts mult_busy_o from the next cycle.
REQ-022 In MUL_RUN the counter decrements each cycle; at count 0 the FSM returns to IDLE and ctrl_o=MUL with ctrl_valid_o is pulsed in the following cycle, giving a total latency of MULT_CYCLES+1.
REQ-023 valid_i while ready_o=0 is ignored and not queued; the requester holds it.
REQ-024 flush_i in MUL_RUN returns the FSM to IDLE next cycle with no ctrl_valid_o pulse.
REQ-025 flush_i together with valid_i in IDLE: flush wins and the request is dropped.
REQ-026 ctrl_o holds its last value between pulses.
REQ-027 The counter is $clog2(MULT_CYCLES+1) bits wide and never wraps below 0.

Reset
REQ-028 reset forces IDLE, counter=0, ctrl_o=0, ctrl_valid_o=0, illegal_o=0, mult_busy_o=0, ready_o=1 immediately, including mid-MUL_RUN.
REQ-029 After reset deassertion the first accept is possible on the first rising edge.

Configuration
REQ-030 Macro ALU_CONTROL_SEQ_MUL_EN defined: MUL decode, MUL_RUN state, counter and mult_busy_o behave as REQ-021..REQ-027.
REQ-031 Macro ALU_CONTROL_SEQ_MUL_EN undefined: func 111 yields ADD with illegal_o=1 at latency 1, MUL_RUN and the counter are absent, and mult_busy_o is tied 0.

Structure
REQ-032 Package alu_ctrl_pkg holds the control-encoding constants, the aluop class constants and the FSM state typedef.
REQ-033 Combinational table lives in sub-module alu_ctrl_decode (aluop, func -> ctrl, is_mul, illegal); alu_control_seq holds FSM, counter and output registers.

Verification
REQ-034 Reset, then aluop=111 func=001 valid 1 cycle -> next cycle ctrl_o=1, ctrl_valid_o=1, illegal_o=0.
REQ-035 Back-to-back accepts aluop 000, 011, 101 -> ctrl_o 0, 2, 4 on three consecutive pulses.
REQ-036 MUL_EN, MULT_CYCLES=8, aluop=111 func=111 -> ready_o low and mult_busy_o high 8 cycles, ctrl_o=7 pulse at cycle 9; valid_i mid-run ignored.
REQ-037 MUL in progress, flush_i at cycle 3 -> IDLE next cycle, no pulse; reset at cycle 5 of a fresh MUL -> all outputs 0, ready_o=1 asynchronously.
REQ-038 aluop=110 -> ctrl_o=0 with illegal_o=1; without MUL_EN, func 111 -> ctrl_o=0, illegal_o=1, latency 1.
REQ-039 MULT_CYCLES=1 -> MUL pulse exactly 2 cycles after accept.
